// File: rtl/img_ram_writer.sv
// Buffers the filtered pixel stream in a small FIFO and writes one frame, in raster order,
// into the filtered-image RAM. Pulses done when the last address has been written.
module img_ram_writer #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              vga_ctrl_clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_last,
  output logic              o_in_ready,
  input  logic              i_mem_stall,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_frame_err
);

  localparam int TOTAL = H_RES * V_RES;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0]  IDX_END   = IDX_W'(TOTAL);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_in_idx;
  logic [ADDR_W-1:0] r_wr_cnt;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_frame_err;

  logic              w_in_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_empty;
  logic              w_store;
  logic              w_take;
  logic [DATA_W-1:0] w_head;

  assign w_fifo_empty = (r_count == '0);
  // An empty FIFO lets an accepted pixel fall straight through to the RAM port.
  assign w_head  = w_fifo_empty ? i_in_data : r_mem[r_rd_ptr];
  assign w_store = w_push && !(w_pop && w_fifo_empty);
  assign w_take  = w_pop && !w_fifo_empty;

  always_ff @(posedge vga_ctrl_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        w_in_ready = (r_count != FULL_CNT) && (r_in_idx != IDX_END);
        w_push     = i_in_valid && w_in_ready;
        w_pop      = !i_mem_stall && (!w_fifo_empty || w_push);
        if (w_pop && (r_wr_cnt == ADDR_LAST)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge vga_ctrl_clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

  always_ff @(posedge vga_ctrl_clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_in_idx    <= '0;
      r_wr_cnt    <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_in_idx    <= '0;
            r_wr_cnt    <= '0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        S_WRITE: begin
          if (w_push) begin
            r_in_idx <= r_in_idx + IDX_W'(1);
            // Frame length is judged on the input side only; writing always covers the full frame.
            if ((i_in_last && (r_in_idx != IDX_LAST)) ||
                (!i_in_last && (r_in_idx == IDX_LAST))) begin
              r_frame_err <= 1'b1;
            end
          end
          if (w_store) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          end
          if (w_take) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
          end
          if (w_store && !w_take) begin
            r_count <= r_count + CNT_W'(1);
          end else if (w_take && !w_store) begin
            r_count <= r_count - CNT_W'(1);
          end
          if (w_pop) begin
            r_wr_en   <= 1'b1;
            r_wr_data <= w_head;
            r_wr_addr <= r_wr_cnt;
            r_wr_cnt  <= r_wr_cnt + ADDR_W'(1);
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_img_ram_writer.sv
// Randomised bench for img_ram_writer on a 4x3 frame; a queue-based model predicts
// every output each cycle, and literal checks pin frame-level results.
module tb_img_ram_writer;

  localparam int H_RES      = 4;
  localparam int V_RES      = 3;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TOTAL      = H_RES * V_RES;

  logic              clk;
  logic              rst;
  logic              iStart;
  logic              iValid;
  logic [DATA_W-1:0] iData;
  logic              iLast;
  logic              iStall;
  logic              oInReady;
  logic              oWrEn;
  logic [ADDR_W-1:0] oWrAddr;
  logic [DATA_W-1:0] oWrData;
  logic              oBusy;
  logic              oDone;
  logic              oFrameErr;

  img_ram_writer #(
    .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .vga_ctrl_clk(clk),
    .rst(rst),
    .i_start(iStart),
    .i_in_valid(iValid),
    .i_in_data(iData),
    .i_in_last(iLast),
    .o_in_ready(oInReady),
    .i_mem_stall(iStall),
    .o_wr_en(oWrEn),
    .o_wr_addr(oWrAddr),
    .o_wr_data(oWrData),
    .o_busy(oBusy),
    .o_done(oDone),
    .o_frame_err(oFrameErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Model: accepted-but-unwritten pixels live in a queue; writes drain it in order.
  logic [DATA_W-1:0] q[$];
  bit                active, finishing, expReady;
  int                acc, wrote;
  bit                expWrEn, expBusy, expDone, expErr;
  int                expAddr;
  logic [DATA_W-1:0] expData;
  int                cycleCnt, wrCount, doneCount, lastAddr, lastWrCycle, doneCycle;

  always @(negedge clk) begin
    cycleCnt++;
    if (rst) begin
      active = 0; finishing = 0; acc = 0; wrote = 0; q.delete();
      expWrEn = 0; expBusy = 0; expDone = 0; expErr = 0; expAddr = 0; expData = '0;
      checkOutput("rstInReady", oInReady, 0);
      checkOutput("rstWrEn", oWrEn, 0);
      checkOutput("rstWrAddr", oWrAddr, 0);
      checkOutput("rstBusy", oBusy, 0);
      checkOutput("rstDone", oDone, 0);
      checkOutput("rstFrameErr", oFrameErr, 0);
    end else begin
      expReady = active && !finishing && (q.size() < FIFO_DEPTH) && (acc < TOTAL);
      checkOutput("inReady", oInReady, expReady);
      checkOutput("wrEn", oWrEn, expWrEn);
      checkOutput("wrAddr", oWrAddr, expAddr);
      checkOutput("wrData", oWrData, expData);
      checkOutput("busy", oBusy, expBusy);
      checkOutput("done", oDone, expDone);
      checkOutput("frameErr", oFrameErr, expErr);
      if (oWrEn) begin
        wrCount++;
        lastAddr = oWrAddr;
        lastWrCycle = cycleCnt;
      end
      if (oDone) begin
        doneCount++;
        doneCycle = cycleCnt;
      end
      expWrEn = 0;
      expDone = 0;
      if (!active) begin
        if (iStart) begin
          active = 1; acc = 0; wrote = 0; q.delete(); expErr = 0; expBusy = 1;
        end
      end else if (finishing) begin
        expDone = 1; expBusy = 0; active = 0; finishing = 0;
      end else begin
        if (iValid && expReady) begin
          if ((iLast && acc != TOTAL - 1) || (!iLast && acc == TOTAL - 1)) expErr = 1;
          q.push_back(iData);
          acc++;
        end
        if (!iStall && q.size() > 0) begin
          expWrEn = 1;
          expData = q.pop_front();
          expAddr = wrote;
          wrote++;
          if (wrote == TOTAL) finishing = 1;
        end
      end
    end
  end

  task automatic applyStimulus(input bit st, input bit v, input bit l, input bit s,
                               input logic [DATA_W-1:0] d, output bit accepted);
    iStart = st; iValid = v; iLast = l; iStall = s; iData = d;
    @(negedge clk);
    accepted = v && oInReady && !rst;
    @(posedge clk);
    #1;
    iStart = 0;
  endtask

  task automatic runFrame(input int lastPos, input int validPct, input int stallPct,
                          input bit seqData, input int midStart, input int stallFrom,
                          input int stallLen, output int stallAcc);
    int pix;
    bit ok, v, s, inWin;
    logic [DATA_W-1:0] d;
    pix = 0;
    stallAcc = 0;
    wrCount = 0;
    doneCount = 0;
    lastAddr = -1;
    applyStimulus(1, 0, 0, 0, '0, ok);
    for (int cyc = 0; cyc < 600 && doneCount == 0; cyc++) begin
      inWin = (cyc >= stallFrom) && (cyc < stallFrom + stallLen);
      v = ($urandom_range(99) < validPct) || inWin;
      s = ($urandom_range(99) < stallPct) || inWin;
      d = seqData ? DATA_W'(pix) : DATA_W'($urandom);
      applyStimulus(cyc == midStart, v, pix == lastPos, s, d, ok);
      if (ok) begin
        pix++;
        if (inWin) stallAcc++;
      end
    end
    checkOutput("frameDoneSeen", doneCount != 0, 1);
    for (int k = 0; k < 3; k++) applyStimulus(0, $urandom_range(1), 0, 0, '0, ok);
  endtask

  initial begin
    int sa, lastPos;
    bit ok;
    rst = 1; iStart = 0; iValid = 0; iData = '0; iLast = 0; iStall = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    $display("[TB] nominal frame");
    runFrame(TOTAL - 1, 100, 0, 1, -1, -1, 0, sa);
    checkOutput("nomWrites", wrCount, 12);
    checkOutput("nomLastAddr", lastAddr, 11);
    checkOutput("nomDoneCount", doneCount, 1);
    checkOutput("nomDoneDelay", doneCycle - lastWrCycle, 1);
    checkOutput("nomFrameErr", oFrameErr, 0);

    $display("[TB] stall backpressure");
    runFrame(TOTAL - 1, 100, 0, 0, -1, 3, 10, sa);
    checkOutput("stallAccepts", sa, 4);
    checkOutput("stallWrites", wrCount, 12);
    checkOutput("stallLastAddr", lastAddr, 11);

    $display("[TB] early last");
    runFrame(7, 100, 0, 1, -1, -1, 0, sa);
    checkOutput("earlyErr", oFrameErr, 1);
    checkOutput("earlyWrites", wrCount, 12);
    checkOutput("earlyDoneCount", doneCount, 1);

    $display("[TB] missing last");
    runFrame(-1, 100, 0, 1, -1, -1, 0, sa);
    checkOutput("missErr", oFrameErr, 1);
    checkOutput("missDoneCount", doneCount, 1);

    $display("[TB] reset mid-frame");
    wrCount = 0;
    doneCount = 0;
    applyStimulus(1, 0, 0, 0, '0, ok);
    for (int k = 0; k < 50 && wrCount < 5; k++) applyStimulus(0, 1, 0, 0, DATA_W'($urandom), ok);
    checkOutput("preResetWrites", wrCount >= 5, 1);
    rst = 1;
    #1;
    checkOutput("asyncWrEn", oWrEn, 0);
    checkOutput("asyncBusy", oBusy, 0);
    checkOutput("asyncInReady", oInReady, 0);
    checkOutput("asyncWrAddr", oWrAddr, 0);
    iValid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    checkOutput("noDoneOnReset", doneCount, 0);
    runFrame(TOTAL - 1, 80, 20, 0, 5, -1, 0, sa);
    checkOutput("restartWrites", wrCount, 12);
    checkOutput("restartLastAddr", lastAddr, 11);
    checkOutput("restartDoneCount", doneCount, 1);

    $display("[TB] random frames");
    for (int f = 0; f < 25; f++) begin
      lastPos = ($urandom_range(3) == 0) ? int'($urandom_range(10)) : TOTAL - 1;
      runFrame(lastPos, 30 + $urandom_range(70), $urandom_range(50), 0, -1, -1, 0, sa);
      checkOutput("randWrites", wrCount, TOTAL);
      checkOutput("randDoneCount", doneCount, 1);
      checkOutput("randFrameErr", oFrameErr, lastPos != TOTAL - 1);
      for (int k = 0; k < $urandom_range(3); k++) applyStimulus(0, 1, 0, 0, '0, ok);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
